// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and defaults for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_MAX_BURST = 4;
  localparam int STAT_W = 16;
endpackage

// File: rtl/fifo_wr_arbiter_rr_select.sv
// rr_select: rotating-priority picker, first set request at or above rr_ptr with wrap
module rr_select #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic [PW-1:0] winner,
  output logic          any_req
);
  assign any_req = |req;
  // scan from farthest to nearest so the nearest set bit after rr_ptr wins
  always_comb begin
    winner = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(rr_ptr) + k) % N]) winner = PW'((int'(rr_ptr) + k) % N);
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port; FIFO_WR_ARBITER_STATS_EN adds beat/stall counters
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int MAX_BURST = DEF_MAX_BURST,
  localparam int GW = $clog2(NUM_REQ),
  localparam int BW = $clog2(MAX_BURST) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_overflow,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy,
`ifdef FIFO_WR_ARBITER_STATS_EN
  output logic [NUM_REQ*STAT_W-1:0]     stat_beats,
  output logic [STAT_W-1:0]             stat_stall,
`endif
  output logic                          err_overflow
);
  state_t state;
  logic [GW-1:0] rr_ptr, winner;
  logic [BW-1:0] burst_cnt;
  logic any_req, can_write, xfer, last;
  rr_select #(.N(NUM_REQ), .PW(GW)) u_sel (
    .req(req_valid),
    .rr_ptr(rr_ptr),
    .winner(winner),
    .any_req(any_req)
  );
  // a registered beat still in flight counts against the last free slot
  assign can_write = !fifo_full && !(fifo_wr_en && fifo_almostfull);
  assign req_ready = (state == GRANT && can_write) ? NUM_REQ'(1) << grant_id : '0;
  assign xfer = state == GRANT && can_write && req_valid[grant_id];
  assign last = xfer && burst_cnt == BW'(MAX_BURST - 1);
  assign busy = state == GRANT;
  // grant FSM plus registered FIFO write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant_id <= '0;
      rr_ptr <= '0;
      burst_cnt <= '0;
      fifo_wr_en <= 1'b0;
      fifo_data_in <= '0;
      err_overflow <= 1'b0;
    end else begin
      fifo_wr_en <= xfer;
      if (xfer) fifo_data_in <= req_data[grant_id*FIFO_WIDTH +: FIFO_WIDTH];
      err_overflow <= err_overflow | fifo_overflow;
      if (state == IDLE) begin
        if (any_req) begin
          grant_id <= winner;
          burst_cnt <= '0;
          state <= GRANT;
        end
      end else if (last || !req_valid[grant_id]) begin
        state <= IDLE;
        rr_ptr <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end else if (xfer) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end
`ifdef FIFO_WR_ARBITER_STATS_EN
  // saturating per-producer beat counters and owner-stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_beats <= '0;
      stat_stall <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (xfer && grant_id == GW'(i) && stat_beats[i*STAT_W +: STAT_W] != '1)
          stat_beats[i*STAT_W +: STAT_W] <= stat_beats[i*STAT_W +: STAT_W] + 1'b1;
      if (state == GRANT && !can_write && req_valid[grant_id] && stat_stall != '1)
        stat_stall <= stat_stall + 1'b1;
    end
  end
`endif
endmodule
